// File: rtl/alu_pkg.sv
// Shared adder-arbiter definitions: datapath width, arbiter FSM states, result payload.
// Pure declarations; no timing or backpressure behaviour of its own.
package alu_pkg;

    localparam int ADDER_W         = 64;
    localparam int DEFAULT_NUM_REQ = 4;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [ADDER_W-1:0] result;
        logic               carry_out;
        logic               last;
    } rsp_dat_t;

endpackage

// File: rtl/adder64_if.sv
// Operand/result bundle between the arbiter and its single shared adder.
// Purely combinational connection; no latency and no flow control.
interface adder64_if;

    logic [alu_pkg::ADDER_W-1:0] a;
    logic [alu_pkg::ADDER_W-1:0] b;
    logic                        cin;
    logic [alu_pkg::ADDER_W-1:0] sum;
    logic                        cout;

    modport dut (input a, b, cin, output sum, cout);

endinterface

// File: rtl/adder64.sv
// Combinational 64-bit adder with carry in/out: {cout, sum} = a + b + cin.
// Zero latency; no backpressure, the result follows the operands.
module adder64 (
    adder64_if.dut add_if
);
    import alu_pkg::*;

    assign {add_if.cout, add_if.sum} = (ADDER_W+1)'(add_if.a) + (ADDER_W+1)'(add_if.b)
                                     + (ADDER_W+1)'(add_if.cin);

endmodule

// File: rtl/add64_arbiter.sv
// Round-robin arbiter sharing one 64-bit adder among NUM_REQ requesters, with chain locking; one-cycle registered result.
// Accepts a beat only when the result register is empty or draining that cycle; the holder of a chain lock blocks everyone else.
module add64_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][ADDER_W-1:0] req_op1,
    input  logic [NUM_REQ-1:0][ADDER_W-1:0] req_op2,
    input  logic [NUM_REQ-1:0]              req_carry_in,
    input  logic [NUM_REQ-1:0]              req_chain,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [IDW-1:0]                  rsp_id,
    output logic [ADDER_W-1:0]              rsp_result,
    output logic                            rsp_carry_out,
    output logic                            rsp_last,
    output logic                            busy
);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           carry_q, carry_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    rsp_dat_t       rsp_q, rsp_d;

    logic           gnt_vld;
    logic [IDW-1:0] gnt_id;
    logic [IDW:0]   cand;
    logic           out_free;
    logic           accept;

    adder64_if add_if ();
    adder64 u_adder64 (.add_if(add_if));

    // A locked chain owner is the only candidate; otherwise scan upward from rr_ptr with wrap.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        if (state_q == ARB_LOCKED) begin
            gnt_vld = req_valid[lock_id_q];
            gnt_id  = lock_id_q;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = {1'b0, rr_ptr_q} + (IDW+1)'(i);
                if (cand >= (IDW+1)'(NUM_REQ)) begin
                    cand = cand - (IDW+1)'(NUM_REQ);
                end
                if (!gnt_vld && req_valid[cand[IDW-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = cand[IDW-1:0];
                end
            end
        end
    end

    assign out_free = !rsp_valid_q || rsp_ready;
    assign accept   = rst_n && gnt_vld && out_free;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign add_if.a   = req_op1[gnt_id];
    assign add_if.b   = req_op2[gnt_id];
    assign add_if.cin = (state_q == ARB_LOCKED) ? carry_q : req_carry_in[gnt_id];

    always_comb begin
        state_d     = state_q;
        lock_id_d   = lock_id_q;
        rr_ptr_d    = rr_ptr_q;
        carry_d     = carry_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_d       = rsp_q;
        if (accept) begin
            rsp_valid_d      = 1'b1;
            rsp_id_d         = gnt_id;
            rsp_d.result     = add_if.sum;
            rsp_d.carry_out  = add_if.cout;
            rsp_d.last       = !req_chain[gnt_id];
            carry_d          = add_if.cout;
            if (req_chain[gnt_id]) begin
                state_d   = ARB_LOCKED;
                lock_id_d = gnt_id;
            end else begin
                state_d  = ARB_IDLE;
                // Fairness only advances once a whole operation (chain) completes.
                rr_ptr_d = (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + IDW'(1);
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            lock_id_q   <= '0;
            rr_ptr_q    <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            lock_id_q   <= lock_id_d;
            rr_ptr_q    <= rr_ptr_d;
            carry_q     <= carry_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_q       <= rsp_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_result    = rsp_q.result;
    assign rsp_carry_out = rsp_q.carry_out;
    assign rsp_last      = rsp_q.last;
    assign busy          = (state_q == ARB_LOCKED) || rsp_valid_q;

endmodule

// File: tb/tb_add64_arbiter.sv
// Bench for add64_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_add64_arbiter;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0][63:0] req_op1;
    logic [N-1:0][63:0] req_op2;
    logic [N-1:0]      req_carry_in;
    logic [N-1:0]      req_chain;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [63:0]       rsp_result;
    logic              rsp_carry_out;
    logic              rsp_last;
    logic              busy;

    int checks = 0;
    int passed = 0;

    // Behavioural model state
    bit          m_locked;
    int          m_owner;
    int          m_rr;
    bit          m_carry;
    bit          m_rsp_valid;
    logic [63:0] m_result;
    bit          m_cout;
    int          m_id;
    bit          m_last;

    add64_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2),
        .req_carry_in(req_carry_in), .req_chain(req_chain),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry_out(rsp_carry_out),
        .rsp_last(rsp_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Which requester should be granted right now (-1 for none).
    function automatic int model_grant();
        if (!rst_n) return -1;
        if (m_rsp_valid && !rsp_ready) return -1;
        if (m_locked) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int g;
        logic [N-1:0] r;
        g = model_grant();
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_rr = 0; m_carry = 0; m_rsp_valid = 0;
        m_result = '0; m_cout = 0; m_id = 0; m_last = 0;
    endtask

    // Advance the model by one clock using the current inputs, then move to 1 ns past the edge.
    task automatic step();
        int g;
        logic [64:0] s;
        bit cin;
        g = model_grant();
        if (!rst_n) begin
            model_reset();
        end else if (g >= 0) begin
            cin = m_locked ? m_carry : req_carry_in[g];
            s = {1'b0, req_op1[g]} + {1'b0, req_op2[g]} + {64'd0, cin};
            m_rsp_valid = 1; m_result = s[63:0]; m_cout = s[64];
            m_id = g; m_last = !req_chain[g]; m_carry = s[64];
            if (req_chain[g]) begin
                m_locked = 1; m_owner = g;
            end else begin
                m_locked = 0; m_rr = (g + 1) % N;
            end
        end else if (rsp_ready) begin
            m_rsp_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_op1 = '0; req_op2 = '0; req_carry_in = '0; req_chain = '0;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                           input bit cin, input bit chain);
        req_valid[i] = 1'b1; req_op1[i] = a; req_op2[i] = b;
        req_carry_in[i] = cin; req_chain[i] = chain;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rsp_ready = 1'b1; clear_inputs();
        req_valid = '1;
        #2;
        checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", req_ready); else passed++;
        step(); step();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passed++;
        checks++; if ({rsp_result, rsp_carry_out, rsp_id, rsp_last} !== 68'd0)
            $display("FAIL reset_rsp_fields got %h/%b/%0d/%b want all zero", rsp_result, rsp_carry_out, rsp_id, rsp_last); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        rst_n = 1'b1; clear_inputs();
    endtask

    task automatic test_single_beat();
        clear_inputs(); rsp_ready = 1'b1;
        set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        #2;
        checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", req_ready); else passed++;
        step(); clear_inputs();
        checks++; if ({rsp_valid, rsp_result, rsp_carry_out, rsp_id, rsp_last} !== {1'b1, 64'd0, 1'b1, 2'd0, 1'b1})
            $display("FAIL single_rsp got v=%b r=%h c=%b id=%0d l=%b want v=1 r=0 c=1 id=0 l=1",
                     rsp_valid, rsp_result, rsp_carry_out, rsp_id, rsp_last); else passed++;
        step();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL single_drain got %b want 0", rsp_valid); else passed++;
    endtask

    task automatic test_chain();
        // A req1 beat first moves the round-robin pointer to 2.
        clear_inputs(); rsp_ready = 1'b1;
        set_req(1, 64'd3, 64'd4, 1'b0, 1'b0);
        step(); clear_inputs();
        set_req(0, 64'd11, 64'd12, 1'b0, 1'b0);
        set_req(1, 64'd13, 64'd14, 1'b0, 1'b0);
        set_req(3, 64'd15, 64'd16, 1'b1, 1'b0);
        set_req(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
        #2;
        checks++; if (req_ready !== 4'b0100) $display("FAIL chain_beat1_ready got %b want 0100", req_ready); else passed++;
        step();
        checks++; if ({rsp_result, rsp_carry_out, rsp_id, rsp_last} !== {64'd0, 1'b1, 2'd2, 1'b0})
            $display("FAIL chain_beat1_rsp got r=%h c=%b id=%0d l=%b want r=0 c=1 id=2 l=0",
                     rsp_result, rsp_carry_out, rsp_id, rsp_last); else passed++;
        set_req(2, 64'd0, 64'd0, 1'b0, 1'b0);
        #2;
        checks++; if (req_ready !== 4'b0100) $display("FAIL chain_beat2_ready got %b want 0100", req_ready); else passed++;
        step(); clear_inputs();
        checks++; if ({rsp_result, rsp_carry_out, rsp_id, rsp_last} !== {64'd1, 1'b0, 2'd2, 1'b1})
            $display("FAIL chain_beat2_rsp got r=%h c=%b id=%0d l=%b want r=1 c=0 id=2 l=1",
                     rsp_result, rsp_carry_out, rsp_id, rsp_last); else passed++;
        step();
    endtask

    task automatic test_round_robin();
        int g;
        // Pointer is 3 after the chain; a req3 beat wraps it to 0.
        clear_inputs(); rsp_ready = 1'b1;
        set_req(3, 64'd1, 64'd1, 1'b0, 1'b0);
        step();
        for (int i = 0; i < N; i++) set_req(i, 64'(100 + i), 64'(i), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            g = k % N;
            #2;
            checks++; if (req_ready !== 4'(1 << g)) $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, 4'(1 << g)); else passed++;
            step();
            checks++; if (rsp_id !== 2'(g) || rsp_result !== 64'(100 + 2 * g))
                $display("FAIL rr_rsp[%0d] got id=%0d r=%0d want id=%0d r=%0d", k, rsp_id, rsp_result, g, 100 + 2 * g); else passed++;
        end
        clear_inputs(); step();
    endtask

    task automatic test_backpressure();
        clear_inputs(); rsp_ready = 1'b1;
        req_valid = '0;
        set_req(0, 64'd5, 64'd7, 1'b1, 1'b0);
        step(); clear_inputs();
        rsp_ready = 1'b0;
        set_req(1, 64'd20, 64'd30, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #2;
            checks++; if (req_ready !== 4'b0000) $display("FAIL bp_ready[%0d] got %b want 0000", k, req_ready); else passed++;
            step();
            checks++; if ({rsp_valid, rsp_result, rsp_id} !== {1'b1, 64'd13, 2'd0})
                $display("FAIL bp_hold[%0d] got v=%b r=%0d id=%0d want v=1 r=13 id=0", k, rsp_valid, rsp_result, rsp_id); else passed++;
        end
        rsp_ready = 1'b1;
        #2;
        checks++; if (req_ready !== 4'b0010) $display("FAIL bp_release_ready got %b want 0010", req_ready); else passed++;
        step(); clear_inputs();
        checks++; if ({rsp_valid, rsp_result, rsp_id} !== {1'b1, 64'd50, 2'd1})
            $display("FAIL bp_release_rsp got v=%b r=%0d id=%0d want v=1 r=50 id=1", rsp_valid, rsp_result, rsp_id); else passed++;
        step();
    endtask

    task automatic test_reset_mid_chain();
        clear_inputs(); rsp_ready = 1'b1;
        set_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
        step(); clear_inputs();
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        set_req(1, 64'd0, 64'd0, 1'b0, 1'b0);
        #2;
        checks++; if (req_ready !== 4'b0000) $display("FAIL rmc_ready_in_reset got %b want 0000", req_ready); else passed++;
        step();
        rst_n = 1'b1; clear_inputs(); rsp_ready = 1'b1;
        checks++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL rmc_after_reset got v=%b busy=%b want 0/0", rsp_valid, busy); else passed++;
        set_req(3, 64'd10, 64'd20, 1'b1, 1'b0);
        #2;
        checks++; if (req_ready !== 4'b1000) $display("FAIL rmc_req3_ready got %b want 1000", req_ready); else passed++;
        step(); clear_inputs();
        checks++; if ({rsp_result, rsp_id, rsp_last} !== {64'd31, 2'd3, 1'b1})
            $display("FAIL rmc_req3_rsp got r=%0d id=%0d l=%b want r=31 id=3 l=1", rsp_result, rsp_id, rsp_last); else passed++;
        step();
    endtask

    task automatic test_stall_in_lock();
        clear_inputs(); rsp_ready = 1'b1;
        set_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
        step(); clear_inputs();
        set_req(0, 64'd9, 64'd9, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #2;
            checks++; if (req_ready !== 4'b0000) $display("FAIL stall_ready[%0d] got %b want 0000", k, req_ready); else passed++;
            step();
            checks++; if (busy !== 1'b1) $display("FAIL stall_busy[%0d] got %b want 1", k, busy); else passed++;
        end
        set_req(1, 64'd0, 64'd0, 1'b0, 1'b0);
        #2;
        checks++; if (req_ready !== 4'b0010) $display("FAIL stall_resume_ready got %b want 0010", req_ready); else passed++;
        step(); clear_inputs();
        checks++; if ({rsp_result, rsp_carry_out, rsp_id, rsp_last} !== {64'd1, 1'b0, 2'd1, 1'b1})
            $display("FAIL stall_resume_rsp got r=%h c=%b id=%0d l=%b want r=1 c=0 id=1 l=1",
                     rsp_result, rsp_carry_out, rsp_id, rsp_last); else passed++;
        step();
    endtask

    task automatic test_random();
        logic [63:0] a, b;
        for (int c = 0; c < 1500; c++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) a = '1;
                if ($urandom_range(0, 3) == 0) b = 64'(1);
                req_valid[i] = $urandom_range(0, 1);
                req_op1[i] = a; req_op2[i] = b;
                req_carry_in[i] = $urandom_range(0, 1);
                req_chain[i] = ($urandom_range(0, 2) == 0);
            end
            #2;
            checks++; if (req_ready !== model_ready()) $display("FAIL rand_ready[%0d] got %b want %b", c, req_ready, model_ready()); else passed++;
            step();
            checks++; if ({rsp_valid, rsp_result, rsp_carry_out, rsp_id, rsp_last, busy} !==
                          {m_rsp_valid, m_result, m_cout, 2'(m_id), m_last, m_locked | m_rsp_valid})
                $display("FAIL rand_rsp[%0d] got v=%b r=%h c=%b id=%0d l=%b busy=%b want v=%b r=%h c=%b id=%0d l=%b busy=%b",
                         c, rsp_valid, rsp_result, rsp_carry_out, rsp_id, rsp_last, busy,
                         m_rsp_valid, m_result, m_cout, m_id, m_last, m_locked | m_rsp_valid); else passed++;
        end
        rst_n = 1'b1; clear_inputs(); rsp_ready = 1'b1;
        step();
    endtask

    initial begin
        model_reset();
        clear_inputs();
        rst_n = 1'b0; rsp_ready = 1'b0;
        #1;
        test_reset();
        test_single_beat();
        test_chain();
        test_round_robin();
        test_backpressure();
        test_reset_mid_chain();
        test_stall_in_lock();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
